frame_reader: RTL and testbench

Frame reader for the Sobel pipeline. It reads a stored frame in raster order from a synchronous-read frame memory and sends it as a valid/ready pixel stream with `last_o`, in the format the pipeline's input port expects. It sits between the frame buffer and `sobel_pipeline`. It sustains one pixel per cycle and absorbs downstream backpressure without losing or duplicating pixels.

---
 rtl/frame_reader.sv | 152 +++++++++++++++
 tb/tb_frame_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// frame_reader: streams a stored frame in raster order from a synchronous-read
// frame memory as a valid/ready pixel stream with last_o. A 2-entry output
// FIFO plus a one-read-in-flight flag lets it run at one pixel per cycle
// while absorbing downstream stalls without dropping or repeating pixels.
module frame_reader #(
  parameter int unsigned WIDTH_P    = 640,
  parameter int unsigned HEIGHT_P   = 480,
  parameter int unsigned CHANNELS_P = 1,
  parameter int unsigned ADDR_W_P   = $clog2(WIDTH_P*HEIGHT_P)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    mem_en_o,
  output logic [ADDR_W_P-1:0]     mem_addr_o,
  input  logic [CHANNELS_P*8-1:0] mem_data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [CHANNELS_P*8-1:0] pixel_o,
  output logic                    last_o
);

  localparam int unsigned DATA_W = CHANNELS_P * 8;
  // Index of the final pixel; both counters stop here so they never wrap.
  localparam logic [ADDR_W_P-1:0] LAST_IDX = ADDR_W_P'(WIDTH_P*HEIGHT_P - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [ADDR_W_P-1:0] rd_cnt_reg;      // address of the next read to issue
  logic                reads_done_reg;  // every pixel of the frame has been requested
  logic [ADDR_W_P-1:0] out_cnt_reg;     // index of the pixel at the FIFO head
  logic                inflight_reg;    // a read was issued last cycle; its data is on mem_data_i now

  logic [DATA_W-1:0]   fifo_mem_reg [2];
  logic                wr_ptr_reg;
  logic                rd_ptr_reg;
  logic [1:0]          count_reg;

  logic                push;
  logic                pop;
  logic                issue;
  logic [2:0]          occupancy;

  // Returned data always lands in the FIFO the cycle it arrives.
  assign push = inflight_reg;
  assign pop  = valid_o && ready_i;

  // Entries the FIFO will hold once everything already requested has arrived,
  // net of this cycle's pop. Keeping it below 2 means a new read always has room.
  assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue     = (state_reg == RUN) && !reads_done_reg && (occupancy < 3'd2);

  assign mem_en_o   = issue;
  assign mem_addr_o = rd_cnt_reg;

  assign valid_o = (count_reg != 2'd0);
  assign pixel_o = fifo_mem_reg[rd_ptr_reg];
  assign last_o  = valid_o && (out_cnt_reg == LAST_IDX);

  assign busy_o = (state_reg == RUN);
  assign done_o = (state_reg == DONE);

  // Frame sequencing, read address counter and output pixel counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg      <= IDLE;
      rd_cnt_reg     <= '0;
      reads_done_reg <= 1'b0;
      out_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            if (rd_cnt_reg == LAST_IDX) begin
              reads_done_reg <= 1'b1;
            end else begin
              rd_cnt_reg <= rd_cnt_reg + ADDR_W_P'(1);
            end
          end
          if (pop) begin
            if (last_o) begin
              state_reg   <= DONE;
              out_cnt_reg <= '0;
            end else begin
              out_cnt_reg <= out_cnt_reg + ADDR_W_P'(1);
            end
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          rd_cnt_reg     <= '0;
          reads_done_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // In-flight flag: clearing it on reset drops any data returning right after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO storage; the head slot is never written while occupied, so a
  // stalled pixel stays stable.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
    // Capture returned memory data into this slot when the write pointer selects it.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        fifo_mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        fifo_mem_reg[gi] <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader on a 4x3 frame. Each
// accepted start pushes the whole frame (memory contents in raster order)
// into an expected queue; an independent monitor pops and compares on every
// handshake and checks timing, stall stability and read-issue invariants.
module tb_frame_reader;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       mem_en_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] pixel_o;
  logic       last_o;

  frame_reader #(
    .WIDTH_P   (W),
    .HEIGHT_P  (H),
    .CHANNELS_P(1),
    .ADDR_W_P  (4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .mem_en_o  (mem_en_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pixel_o   (pixel_o),
    .last_o    (last_o)
  );

  always #5 clk = ~clk;

  // Frame memory model: synchronous read.
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (mem_en_o) mem_data_i <= mem[mem_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  int checks = 0;
  int passes = 0;
  int hs_count = 0;   // handshakes in the current frame
  int rd_issued = 0;  // reads issued in the current frame
  int last_total = 0;
  int hs_cyc [N];

  bit   rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ready_i driver: random 50% or a fixed level.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor / scoreboard.
  initial begin : monitor
    bit         last_seen;
    bit         prev_stall;
    bit         pop;
    logic [7:0] prev_pix;
    logic       prev_last;
    logic [7:0] e;
    last_seen  = 0;
    prev_stall = 0;
    prev_pix   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_i !== 1'b0) begin
        hs_count   = 0;
        rd_issued  = 0;
        last_seen  = 0;
        prev_stall = 0;
      end else begin
        pop = valid_o && ready_i;
        chk("done_pulse", done_o, last_seen);
        if (last_seen) begin
          chk("busy_in_done", busy_o, 0);
          chk("no_read_in_done", mem_en_o, 0);
          chk("frame_pixels", hs_count, N);
          chk("frame_reads", rd_issued, N);
          hs_count  = 0;
          rd_issued = 0;
        end
        last_seen = 0;
        if (last_o) chk("last_needs_valid", valid_o, 1);
        if (prev_stall) begin
          chk("stall_hold_pixel", pixel_o, prev_pix);
          chk("stall_hold_last", last_o, prev_last);
        end
        if (mem_en_o) begin
          chk("read_addr", mem_addr_o, rd_issued);
          chk("read_room", (rd_issued - hs_count - (pop ? 1 : 0)) < 2, 1);
          rd_issued++;
        end
        if (pop) begin
          chk("exp_available", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pixel", pixel_o, e);
            chk("last", last_o, hs_count == N - 1);
          end
          if (hs_count < N) hs_cyc[hs_count] = cyc;
          if (hs_count == N - 1) last_seen = 1;
          if (last_o) last_total++;
          hs_count++;
        end
        prev_stall = valid_o && !ready_i;
        prev_pix   = pixel_o;
        prev_last  = last_o;
      end
    end
  end

  task automatic start_frame(output int c0);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
    @(posedge clk);
    #1;
    c0 = cyc;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (done_o) break;
    end
    chk("done_seen", done_o, 1);
  endtask

  task automatic wait_hs(input int n);
    for (int k = 0; k < 200; k++) begin
      if (hs_count >= n) break;
      @(posedge clk);
      #1;
    end
    chk("hs_reached", hs_count >= n, 1);
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_pixel", pixel_o, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
  endtask

  task automatic check_back_to_back(input string name);
    for (int i = 1; i < N; i++) chk(name, hs_cyc[i] - hs_cyc[i-1], 1);
  endtask

  initial begin : stimulus
    int c0;
    reset_i = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_reset_values();

    // Full frame, no backpressure, memory[i] = i.
    rdy_rand = 0; rdy_val = 1'b1;
    start_frame(c0);
    wait_done(100);
    chk("first_pixel_cycle", hs_cyc[0] - c0, 2);
    chk("last_pixel_cycle", hs_cyc[N-1] - c0, 2 + N - 1);
    check_back_to_back("no_bp_gap");

    // Random backpressure over several frames with random contents.
    rdy_rand = 1;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      start_frame(c0);
      wait_done(300);
    end

    // Long stall after the first valid, then release.
    rdy_rand = 0; rdy_val = 1'b0;
    fill_random();
    start_frame(c0);
    for (int k = 0; k < 20; k++) begin
      if (valid_o) break;
      @(posedge clk);
      #1;
    end
    chk("stall_first_valid", valid_o, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_reads", rd_issued, 2);
    chk("stall_valid", valid_o, 1);
    rdy_val = 1'b1;
    wait_done(100);
    check_back_to_back("release_gap");

    // Start pulsed mid-frame and during the done cycle.
    rdy_rand = 1;
    fill_random();
    start_frame(c0);
    wait_hs(5);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(300);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_after_done_busy", busy_o, 0);
      chk("idle_after_done_valid", valid_o, 0);
    end
    chk("no_restart_queue", exp_q.size(), 0);

    // Reset mid-frame after pixel 5 is accepted.
    rdy_rand = 0; rdy_val = 1'b1;
    fill_random();
    start_frame(c0);
    wait_hs(6);
    reset_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    check_reset_values();
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_valid", valid_o, 0);
    end
    fill_random();
    start_frame(c0);
    wait_done(100);

    // Back-to-back frames: restart on the first cycle after done_o.
    fill_random();
    last_total = 0;
    start_frame(c0);
    wait_done(100);
    start_frame(c0);
    chk("b2b_restart_busy", busy_o, 1);
    wait_done(100);
    @(negedge clk);
    chk("last_count", last_total, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
